// File: rtl/ram_stream_reader_pkg.sv
// Shared FSM state type and output buffer depth for ram_stream_reader.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/ram_stream_reader_skid_fifo.sv
// Two-entry output buffer; the head register drives the stream directly.
module stream_skid_fifo
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (r_count == 2'd0) begin
      if (i_push) begin
        r_head  <= i_data;
        r_count <= 2'd1;
      end
    end else if (r_count == 2'd1) begin
      if (i_push && i_pop) begin
        r_head <= i_data;
      end else if (i_push) begin
        r_tail  <= i_data;
        r_count <= 2'(BUF_DEPTH);
      end else if (i_pop) begin
        r_count <= 2'd0;
      end
    end else if (i_pop) begin
      // Full: tail moves to head; a simultaneous push refills the tail.
      r_head <= r_tail;
      if (i_push) r_tail <= i_data;
      else        r_count <= 2'd1;
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a block of words out of a sync-read RAM as a valid/ready stream.
// Optional m_last output enabled by defining RAM_STREAM_LAST_EN.
module ram_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
`ifdef RAM_STREAM_LAST_EN
  output logic                  m_last,
`endif
  input  logic                  m_ready
);

  import ram_stream_reader_pkg::*;

`ifdef RAM_STREAM_LAST_EN
  localparam int unsigned FW = DATA_WIDTH + 1;
`else
  localparam int unsigned FW = DATA_WIDTH;
`endif

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issued;
  logic [LEN_WIDTH-1:0]  r_beats;
  logic                  r_inflight;
  logic [1:0]            w_count;
  logic [2:0]            w_occ;
  logic [FW-1:0]         w_push_data;
  logic [FW-1:0]         w_head;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_last_beat;
  logic                  w_issue;

  assign w_accept    = (r_state == ST_IDLE) && start;
  assign m_valid     = (w_count != 2'd0);
  assign w_beat      = m_valid && m_ready;
  assign w_last_beat = w_beat && ((r_beats + LEN_WIDTH'(1)) == r_len);
  // Buffer occupancy after this cycle's push/pop; at most one extra read may be outstanding.
  assign w_occ       = 3'(w_count) + 3'(r_inflight) - 3'(w_beat);
  assign w_issue     = (r_state == ST_RUN) && (r_issued < r_len) && (w_occ < 3'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_next = (length == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_last_beat) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
    done = (r_state == ST_DONE);
  end

  // ram_addr_r is preloaded on accept; an issue is the edge at which the RAM samples it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ram_addr <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_beats    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept) begin
        r_ram_addr <= start_addr;
        r_len      <= length;
        r_issued   <= '0;
        r_beats    <= '0;
      end else begin
        if (w_issue) begin
          r_ram_addr <= r_ram_addr + ADDR_WIDTH'(1);
          r_issued   <= r_issued + LEN_WIDTH'(1);
        end
        if (w_beat) r_beats <= r_beats + LEN_WIDTH'(1);
      end
    end
  end

  assign ram_addr_r = r_ram_addr;

`ifdef RAM_STREAM_LAST_EN
  logic r_inflight_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_inflight_last <= 1'b0;
    else          r_inflight_last <= w_issue && ((r_issued + LEN_WIDTH'(1)) == r_len);
  end

  assign w_push_data = {r_inflight_last, ram_data};
  assign m_last      = m_valid && w_head[DATA_WIDTH];
`else
  assign w_push_data = ram_data;
`endif

  stream_skid_fifo #(
    .WIDTH(FW)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .i_push (r_inflight),
    .i_data (w_push_data),
    .i_pop  (w_beat),
    .o_head (w_head),
    .o_count(w_count)
  );

  assign m_data = w_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: vector table plus reset and full-RAM sequences.
module tb_ram_stream_reader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [11:0] start_addr;
  logic [12:0] length;
  logic        busy;
  logic        done;
  logic [11:0] ram_addr_r;
  logic [7:0]  ram_data;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
`ifdef RAM_STREAM_LAST_EN
  logic        m_last;
`endif

  logic [7:0] mem [4096];

  int n_checks;
  int n_pass;

  typedef struct {
    logic [11:0] addr;
    logic [12:0] len;
    logic [15:0] rdy;
    logic [31:0] exp;
    int          lat;
    int          rs_cyc;
  } vec_t;

  vec_t vecs [8];

  ram_stream_reader #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(12),
    .LEN_WIDTH (13)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .ram_addr_r(ram_addr_r),
    .ram_data  (ram_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
`ifdef RAM_STREAM_LAST_EN
    .m_last    (m_last),
`endif
    .m_ready   (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ram_data <= mem[ram_addr_r];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    int          cyc, beats, first_lat, done_cyc, last_cyc, exp_done;
    bit          busy_bad, stall_bad, prev_stall;
    logic [7:0]  prev_data;
    logic [31:0] e;
    v = vecs[idx];
    beats = 0; first_lat = -1; done_cyc = -1; last_cyc = 0;
    busy_bad = 0; stall_bad = 0; prev_stall = 0; prev_data = '0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = v.addr; length = v.len; m_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 300) begin
      if (cyc == v.rs_cyc) begin
        start = 1'b1; start_addr = 12'h300; length = 13'd2;
      end else begin
        start = 1'b0;
      end
      if (busy !== 1'b1) busy_bad = 1;
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stall_bad = 1;
      if (m_valid === 1'b1 && first_lat < 0) first_lat = cyc;
      if (done === 1'b1) begin
        done_cyc = cyc;
        m_ready  = 1'b0;
      end else begin
        m_ready = v.rdy[cyc % 16];
        if (m_valid === 1'b1 && m_ready) begin
          if (beats < 4) begin
            e = v.exp >> (8 * beats);
            check($sformatf("v%0d_data%0d", idx, beats), {24'h0, m_data}, {24'h0, e[7:0]});
          end
`ifdef RAM_STREAM_LAST_EN
          check($sformatf("v%0d_last%0d", idx, beats), {31'h0, m_last},
                {31'h0, (beats == int'(v.len) - 1)});
`endif
          beats++;
          last_cyc = cyc;
        end
        prev_stall = (m_valid === 1'b1) && !m_ready;
        prev_data  = m_data;
        @(posedge clk); #1;
        cyc++;
      end
    end
    exp_done = (v.len == '0) ? 1 : last_cyc + 1;
    check($sformatf("v%0d_done_seen", idx), {31'h0, (done_cyc >= 0)}, 32'h1);
    check($sformatf("v%0d_done_cycle", idx), done_cyc, exp_done);
    check($sformatf("v%0d_beats", idx), beats, {19'h0, v.len});
    check($sformatf("v%0d_first_valid", idx), first_lat, v.lat);
    check($sformatf("v%0d_busy_high", idx), {31'h0, busy_bad}, 32'h0);
    check($sformatf("v%0d_stall_hold", idx), {31'h0, stall_bad}, 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("v%0d_busy_after", idx), {31'h0, busy}, 32'h0);
    check($sformatf("v%0d_done_after", idx), {31'h0, done}, 32'h0);
  endtask

  initial begin
    int         beats, errs;
    logic [7:0] lastd;
    bit         seen_done;
    n_checks = 0; n_pass = 0;
    reset_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; m_ready = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] a;
      a = 12'(i);
      mem[i] = a[7:0] ^ {a[11:8], 4'h0};
    end
    mem[16] = 8'hA0; mem[17] = 8'hA1; mem[18] = 8'hA2; mem[19] = 8'hA3;

    //          addr     len     ready     expected bytes   lat restart
    vecs[0] = '{12'h010, 13'd4, 16'hFFFF, 32'hA3A2A1A0,    3,  0};
    vecs[1] = '{12'h010, 13'd4, 16'h6A59, 32'hA3A2A1A0,    3,  0};
    vecs[2] = '{12'hFFE, 13'd4, 16'hFFFF, 32'h01000F0E,    3,  0};
    vecs[3] = '{12'h055, 13'd0, 16'hFFFF, 32'h00000000,   -1,  0};
    vecs[4] = '{12'h010, 13'd4, 16'hFFFF, 32'hA3A2A1A0,    3,  2};
    vecs[5] = '{12'h123, 13'd3, 16'hFFFF, 32'h00353433,    3,  6};
    vecs[6] = '{12'h200, 13'd1, 16'h5555, 32'h00000020,    3,  0};
    vecs[7] = '{12'h500, 13'd2, 16'hFFFF, 32'h00005150,    3,  0};

    #1;
    check("rst_busy",  {31'h0, busy},    32'h0);
    check("rst_done",  {31'h0, done},    32'h0);
    check("rst_valid", {31'h0, m_valid}, 32'h0);
    check("rst_data",  {24'h0, m_data},  32'h0);
    check("rst_addr",  {20'h0, ram_addr_r}, 32'h0);
    #21 reset_n = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(k);

    // Reset two beats into an 8-word transfer
    @(posedge clk); #1;
    start = 1'b1; start_addr = 12'h400; length = 13'd8; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      if (m_valid === 1'b1) beats++;
      @(posedge clk); #1;
    end
    check("t6_two_beats", beats, 2);
    #2 reset_n = 1'b0;
    #1;
    check("t6_busy",  {31'h0, busy},    32'h0);
    check("t6_done",  {31'h0, done},    32'h0);
    check("t6_valid", {31'h0, m_valid}, 32'h0);
    check("t6_data",  {24'h0, m_data},  32'h0);
    check("t6_addr",  {20'h0, ram_addr_r}, 32'h0);
    seen_done = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) reset_n = 1'b1;
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1;
    end
    check("t6_no_done", {31'h0, seen_done}, 32'h0);
    m_ready = 1'b0;
    run_vec(7);

    // Full-RAM transfer wrapping through address 0
    @(posedge clk); #1;
    start = 1'b1; start_addr = 12'h800; length = 13'h1000; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beats = 0; errs = 0; lastd = '0; seen_done = 0;
    for (int c = 0; c < 5000 && !seen_done; c++) begin
      if (done === 1'b1) begin
        seen_done = 1;
      end else begin
        if (m_valid === 1'b1) begin
          if (m_data !== mem[(32'h800 + beats) % 4096]) errs++;
          lastd = m_data;
          beats++;
        end
        @(posedge clk); #1;
      end
    end
    check("full_done_seen", {31'h0, seen_done}, 32'h1);
    check("full_beats", beats, 4096);
    check("full_data_errs", errs, 0);
    check("full_last_word", {24'h0, lastd}, 32'h8F);
    @(posedge clk); #1;
    check("full_busy_after", {31'h0, busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
